aemb_dwb_sram: RTL
==================

AEMB_DWB_SRAM -- requirements
Module: aemb_dwb_sram

Interface
- REQ-001 Parameter: DSIZ, default 16, byte-address width of the data bus; array depth is 2^(DSIZ-2) 32-bit words.
- REQ-002 Parameter: WAIT, default 1, wait states inserted before ack; legal range 0..15.
- REQ-003 Port: sys_clk_i, in, 1, single clock; all logic on its rising edge.
- REQ-004 Port: sys_rst_i, in, 1, asynchronous active-low reset.
- REQ-005 Port: dwb_stb_i, in, 1, strobe from core; a transfer is requested while high.
- REQ-006 Port: dwb_we_i, in, 1, 1 = write, 0 = read.
- REQ-007 Port: dwb_adr_i, in, DSIZ, byte address; bits [1:0] ignored.
- REQ-008 Port: dwb_dat_i, in, 32, write data.
- REQ-009 Port: dwb_sel_i, in, 4, byte-lane enables; bit 3 = dat[31:24].
- REQ-010 Port: dwb_ack_o, out, 1, one-cycle transfer-complete pulse.
- REQ-011 Port: dwb_dat_o, out, 32, registered read data.

Function
- REQ-012 FSM states: IDLE, WAIT, ACK.
- REQ-013 IDLE: on a rising edge with dwb_stb_i = 1, capture adr/we/dat/sel and go to WAIT if WAIT > 0, else go to ACK.
- REQ-014 WAIT: a 4-bit counter loads WAIT-1 on entry, decrements each cycle, and moves to ACK when it is 0 and dwb_stb_i = 1.
- REQ-015 ACK: dwb_ack_o = 1 for exactly this one cycle, then unconditionally IDLE.
- REQ-016 Latency: from the edge sampling stb in IDLE to ack high is WAIT+1 cycles.
- REQ-017 Back-to-back throughput is one transfer per WAIT+2 cycles; stb held high after ack starts a new transfer from IDLE.
- REQ-018 Write commits to the array on the edge entering ACK, using the captured address and data.
- REQ-019 Read: dwb_dat_o is updated on the edge entering ACK and holds until the next read completes; writes leave dwb_dat_o unchanged.
- REQ-020 Abort: dwb_stb_i = 0 in WAIT returns to IDLE with no ack, no array write and no dwb_dat_o update.
- REQ-021 Address wrap: only adr[DSIZ-1:2] indexes the array, and higher addresses alias modulo depth.
- REQ-022 A read to the address just written returns the new data (write-then-read coherency).

Reset
- REQ-023 sys_rst_i low forces IDLE, counter = 0, dwb_ack_o = 0 and dwb_dat_o = 32'h0 immediately, independent of the clock.
- REQ-024 Reset mid-transfer discards the transfer, and no array write occurs.
- REQ-025 Array contents are not reset.

Configuration
- REQ-026 Macro AEMB_DWB_SEL_EN defined: writes update only the lanes with dwb_sel_i set; sel = 4'b0000 completes with ack and no change.
- REQ-027 Macro AEMB_DWB_SEL_EN undefined: dwb_sel_i is ignored (port retained) and every write updates all 32 bits.

Structure
- REQ-028 Shared package aemb_pkg holds the FSM state enum, the word-width constant (32) and the lane-count constant (4).
- REQ-029 Sub-module aemb_sram_core holds the storage array with a synchronous write port (per-lane enables) and a synchronous read port, and contains no FSM.

Verification
- REQ-030 WAIT=1: write 0xDEADBEEF to 0x0010, then read 0x0010 -> ack 2 cycles after each stb sample; read data 0xDEADBEEF.
- REQ-031 WAIT=0, stb held high for 3 reads of 0x0,0x4,0x8 -> exactly 3 one-cycle acks, 2 cycles apart.
- REQ-032 AEMB_DWB_SEL_EN defined: write 0xFFFFFFFF to 0x20, then write 0x12345678 with sel=4'b0101 -> read 0x20 returns 0xFF34FF78; with the macro undefined it returns 0x12345678.
- REQ-033 WAIT=3: stb dropped in the 2nd WAIT cycle of a write of 0xAAAA5555 to 0x40 -> no ack, and a later read of 0x40 returns its prior value.
- REQ-034 Reset asserted while in WAIT -> ack stays 0, dwb_dat_o = 0, state IDLE, and the target word is unchanged.
- REQ-035 DSIZ=16: write 0xCAFEF00D to 0x10004 (upper bit truncated by the bench) -> read 0x0004 returns 0xCAFEF00D.

Source files
------------

// File: rtl/aemb_pkg.sv
// aemb_pkg -- shared definitions for the AEMB data-bus SRAM slice.
//   AEMB_WORD_W : data word width in bits (32)
//   AEMB_LANES  : byte lanes per word (4)
//   aemb_state_t: bus-slave FSM states (IDLE, WAIT, ACK)
package aemb_pkg;

  localparam int unsigned AEMB_WORD_W = 32;
  localparam int unsigned AEMB_LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } aemb_state_t;

endpackage

// File: rtl/aemb_sram_core.sv
// aemb_sram_core -- word-organised storage array, no control logic.
//   clk    : clock, all ports synchronous to its rising edge
//   rst_n  : asynchronous active-low reset, clears the read register only
//   wr_en  : per-byte-lane write enables (bit 3 = data[31:24])
//   wr_adr : write word address
//   wr_dat : write data
//   rd_en  : loads rd_dat from rd_adr on the next edge
//   rd_adr : read word address
//   rd_dat : registered read data, holds while rd_en is low
module aemb_sram_core
  import aemb_pkg::*;
#(
  parameter int unsigned AW = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AEMB_LANES-1:0]  wr_en,
  input  logic [AW-1:0]          wr_adr,
  input  logic [AEMB_WORD_W-1:0] wr_dat,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_adr,
  output logic [AEMB_WORD_W-1:0] rd_dat
);

  // Storage is deliberately not reset.
  logic [AEMB_WORD_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < AEMB_LANES; l++) begin
      if (wr_en[l]) begin
        mem[wr_adr][l*8 +: 8] <= wr_dat[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[rd_adr];
    end
  end

endmodule

// File: rtl/aemb_dwb_sram.sv
// aemb_dwb_sram -- AEMB data-bus (DWB) slave in front of a single-port SRAM.
//   Parameters: DSIZ (byte-address width, depth 2^(DSIZ-2) words),
//               WAIT (wait states before ack, 0..15).
//   sys_clk_i  : clock
//   sys_rst_i  : asynchronous active-low reset
//   dwb_stb_i  : transfer request
//   dwb_we_i   : 1 = write, 0 = read
//   dwb_adr_i  : byte address, bits [1:0] ignored
//   dwb_dat_i  : write data
//   dwb_sel_i  : byte-lane enables (bit 3 = dat[31:24])
//   dwb_ack_o  : one-cycle completion pulse
//   dwb_dat_o  : registered read data, held until the next read completes
// Build option: define AEMB_DWB_SEL_EN to honour dwb_sel_i on writes;
// otherwise every write updates the full word.
module aemb_dwb_sram
  import aemb_pkg::*;
#(
  parameter int unsigned DSIZ = 16,
  parameter int unsigned WAIT = 1
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_i,
  input  logic                   dwb_stb_i,
  input  logic                   dwb_we_i,
  input  logic [DSIZ-1:0]        dwb_adr_i,
  input  logic [AEMB_WORD_W-1:0] dwb_dat_i,
  input  logic [AEMB_LANES-1:0]  dwb_sel_i,
  output logic                   dwb_ack_o,
  output logic [AEMB_WORD_W-1:0] dwb_dat_o
);

  localparam int unsigned AW = DSIZ - 2;
  localparam logic [3:0] WAIT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  aemb_state_t            state, state_nx;
  logic [3:0]             cnt;
  logic                   we_q;
  logic [AW-1:0]          adr_q;
  logic [AEMB_WORD_W-1:0] dat_q;
  logic [AEMB_LANES-1:0]  sel_q;

  logic                   go_ack;
  logic                   x_we;
  logic [AW-1:0]          x_adr;
  logic [AEMB_WORD_W-1:0] x_dat;
  logic [AEMB_LANES-1:0]  x_lanes;
  logic [AEMB_LANES-1:0]  wr_en;
  logic                   rd_en;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (dwb_stb_i) state_nx = (WAIT == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: begin
        if (!dwb_stb_i)     state_nx = ST_IDLE;
        else if (cnt == '0) state_nx = ST_ACK;
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dwb_ack_o <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
    end else begin
      state     <= state_nx;
      dwb_ack_o <= go_ack;
      if (state == ST_IDLE && dwb_stb_i) begin
        cnt   <= WAIT_LD;
        we_q  <= dwb_we_i;
        adr_q <= dwb_adr_i[DSIZ-1:2];
        dat_q <= dwb_dat_i;
        sel_q <= dwb_sel_i;
      end else if (state == ST_WAIT && dwb_stb_i && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // With WAIT=0 the array is accessed on the same edge that captures the
  // request, so the live bus fields are used in IDLE and the captured ones
  // afterwards. Gating by reset keeps a request held during reset from
  // reaching the array.
  assign go_ack = sys_rst_i && (state_nx == ST_ACK);
  assign x_we   = (state == ST_IDLE) ? dwb_we_i             : we_q;
  assign x_adr  = (state == ST_IDLE) ? dwb_adr_i[DSIZ-1:2]  : adr_q;
  assign x_dat  = (state == ST_IDLE) ? dwb_dat_i            : dat_q;

`ifdef AEMB_DWB_SEL_EN
  assign x_lanes = (state == ST_IDLE) ? dwb_sel_i : sel_q;
  logic unused_bits;
  assign unused_bits = ^dwb_adr_i[1:0];
`else
  assign x_lanes = '1;
  logic unused_bits;
  assign unused_bits = ^{dwb_adr_i[1:0], sel_q};
`endif

  assign wr_en = (go_ack && x_we) ? x_lanes : '0;
  assign rd_en = go_ack && !x_we;

  aemb_sram_core #(
    .AW (AW)
  ) u_core (
    .clk    (sys_clk_i),
    .rst_n  (sys_rst_i),
    .wr_en  (wr_en),
    .wr_adr (x_adr),
    .wr_dat (x_dat),
    .rd_en  (rd_en),
    .rd_adr (x_adr),
    .rd_dat (dwb_dat_o)
  );

endmodule
